// File: rtl/fetch_stage_pkg.sv
// Shared RV32I pipeline definitions: NOP encoding and the IF/ID register
// layout, also consumed by the decode stage.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            fault;
  } if_id_t;

  // Value the IF/ID register takes on reset and on a redirect flush.
  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0,
    fault:    1'b0
  };

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: hazard unit,
// execute-stage redirect, instruction memory and the decode stage.
//
// Control semantics: there is no valid/ready pair here. stall_f=1 at a
// rising edge freezes PC and IF/ID; redirect_e=1 at a rising edge loads
// target_e (word-aligned) into PC and flushes IF/ID, winning over stall_f.
// valid_d marks IF/ID as holding a real instruction; decode consumes it on
// every edge where stall_f is low. imem_rdata must respond to imem_addr
// combinationally within the same cycle.
interface fetch_stage_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);
  logic                     stall_f;
  logic                     redirect_e;
  logic [ADDRESS_WIDTH-1:0] target_e;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0]   imem_rdata;
  logic [INSTR_WIDTH-1:0]   instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
  logic                     valid_d;
  logic                     fault_d;

  // Environment side: hazard unit, execute, instruction memory, decode.
  modport master (
    output stall_f, redirect_e, target_e, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fault_d
  );

  // Fetch stage side.
  modport slave (
    input  stall_f, redirect_e, target_e, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fault_d
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats stall so a redirect always leaves a
// bubble even when the hazard unit is holding the pipe.
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Bubble on reset/flush, hold on stall, otherwise capture the new fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, fetch-fault
// tagging and the IF/ID register feeding decode.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = XLEN,
  parameter int                       INSTR_WIDTH   = ILEN,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] IMEM_BYTES    = ADDRESS_WIDTH'(4096)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.slave bus
);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     misalign;
  logic                     out_of_range;
  logic                     fetch_fault;
  if_id_t                   fetch_entry;
  if_id_t                   if_id_q;

  // Wraps modulo 2^ADDRESS_WIDTH; the top word is already faulted by range.
  assign pc_plus4     = pc + ADDRESS_WIDTH'(4);
  assign out_of_range = (pc >= IMEM_BYTES);
  // misalign remembers that the current PC came from a misaligned target.
  assign fetch_fault  = misalign | out_of_range;
  assign bus.imem_addr = pc;

  // Entry captured on an advance; faulted fetches carry NOP but stay valid
  // so decode/trap logic sees them in program order.
  always_comb begin
    fetch_entry          = IF_ID_BUBBLE;
    fetch_entry.instr    = fetch_fault ? NOP_INSTR : bus.imem_rdata;
    fetch_entry.pc       = pc;
    fetch_entry.pc_plus4 = pc_plus4;
    fetch_entry.valid    = 1'b1;
    fetch_entry.fault    = fetch_fault;
  end

  // PC and sticky misalign flag: redirect > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (bus.redirect_e) begin
      pc       <= {bus.target_e[ADDRESS_WIDTH-1:2], 2'b00};
      misalign <= is_misaligned(bus.target_e);
    end else if (!bus.stall_f) begin
      pc       <= pc_plus4;
      misalign <= 1'b0;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (bus.stall_f),
    .flush (bus.redirect_e),
    .d     (fetch_entry),
    .q     (if_id_q)
  );

  assign bus.instr_d    = if_id_q.instr;
  assign bus.pc_d       = if_id_q.pc;
  assign bus.pc_plus4_d = if_id_q.pc_plus4;
  assign bus.valid_d    = if_id_q.valid;
  assign bus.fault_d    = if_id_q.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed redirect/stall/fault scenarios, a
// spec-level reference model compared every cycle, and literal pins.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'h0000_1000;

  logic clk;
  logic rst;

  fetch_stage_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= LIMIT) return 32'hBAD0_0000 | {16'h0, a[15:0]};
    if (a == 32'h0) return 32'h0050_0093;
    return 32'hA000_0000 | a;
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  // ---------------- reference model ----------------
  // Expected fetch-stage state derived from the stage's rules per edge.
  logic [31:0] m_pc, m_instr, m_pc_d, m_pc4;
  logic        m_valid, m_fault, m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pc_d = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0; m_mis = 1'b0;
    end else if (bus.redirect_e) begin
      m_pc    = bus.target_e & ~32'h3;
      m_mis   = (bus.target_e % 4) != 0;
      m_instr = NOP; m_pc_d = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0;
    end else if (!bus.stall_f) begin
      m_fault = m_mis || (m_pc >= LIMIT);
      m_instr = m_fault ? NOP : mem_word(m_pc);
      m_pc_d  = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_mis   = 1'b0;
      m_pc    = m_pc + 32'd4;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model imem_addr",  bus.imem_addr,  m_pc);
      check("model instr_d",    bus.instr_d,    m_instr);
      check("model pc_d",       bus.pc_d,       m_pc_d);
      check("model pc_plus4_d", bus.pc_plus4_d, m_pc4);
      check("model valid_d",    32'(bus.valid_d), 32'(m_valid));
      check("model fault_d",    32'(bus.fault_d), 32'(m_fault));
    end
  end

  // ---------------- driver ----------------
  // Apply inputs for one edge, return at the following falling edge.
  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    bus.stall_f    = s;
    bus.redirect_e = r;
    bus.target_e   = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pin(input string tag, input logic [31:0] instr, input logic [31:0] pcd,
                     input logic v, input logic f);
    check({tag, " instr_d"}, bus.instr_d, instr);
    check({tag, " pc_d"},    bus.pc_d,    pcd);
    check({tag, " valid_d"}, 32'(bus.valid_d), 32'(v));
    check({tag, " fault_d"}, 32'(bus.fault_d), 32'(f));
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    bus.stall_f = 1'b0; bus.redirect_e = 1'b0; bus.target_e = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    run_cmp = 1'b1;
    check("reset imem_addr", bus.imem_addr, 32'h0);
    pin("reset", NOP, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // first fetch after reset release
    cyc(1'b0, 1'b0, 32'h0);
    pin("first", 32'h0050_0093, 32'h0, 1'b1, 1'b0);
    check("first pc_plus4_d", bus.pc_plus4_d, 32'h4);

    // stall three cycles at PC=8, then release
    cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      check("stall imem_addr", bus.imem_addr, 32'h8);
      pin("stall", 32'hA000_0004, 32'h4, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0);
    pin("release", 32'hA000_0008, 32'h8, 1'b1, 1'b0);

    // redirect overrides concurrent stall
    cyc(1'b1, 1'b1, 32'h40);
    pin("redir bubble", NOP, 32'h0, 1'b0, 1'b0);
    check("redir imem_addr", bus.imem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    pin("redir target", 32'hA000_0040, 32'h40, 1'b1, 1'b0);

    // misaligned target
    cyc(1'b0, 1'b1, 32'h42);
    check("misalign imem_addr", bus.imem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    pin("misalign entry", NOP, 32'h40, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    pin("misalign after", 32'hA000_0044, 32'h44, 1'b1, 1'b0);

    // misaligned flag held across a stall, then consumed
    cyc(1'b0, 1'b1, 32'h61);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    pin("misalign stalled", NOP, 32'h60, 1'b1, 1'b1);

    // second redirect replaces pending misalign flag
    cyc(1'b0, 1'b1, 32'h82);
    cyc(1'b0, 1'b1, 32'h100);
    cyc(1'b0, 1'b0, 32'h0);
    pin("flag replaced", 32'hA000_0100, 32'h100, 1'b1, 1'b0);

    // sequential fetch into the out-of-range boundary
    cyc(1'b0, 1'b1, 32'hFF8);
    cyc(1'b0, 1'b0, 32'h0);
    pin("range ff8", 32'hA000_0FF8, 32'hFF8, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    pin("range ffc", 32'hA000_0FFC, 32'hFFC, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    pin("range 1000", NOP, 32'h1000, 1'b1, 1'b1);

    // top-of-address-space wrap
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0);
    pin("wrap top", NOP, 32'hFFFF_FFFC, 1'b1, 1'b1);
    check("wrap pc_plus4_d", bus.pc_plus4_d, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    pin("wrap zero", 32'h0050_0093, 32'h0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle with PC=0x20
    cyc(1'b0, 1'b1, 32'h20);
    cyc(1'b0, 1'b0, 32'h0);
    check("pre-reset pc_d", bus.pc_d, 32'h20);
    #2 rst = 1'b1;
    #1;
    check("async imem_addr", bus.imem_addr, 32'h0);
    pin("async", NOP, 32'h0, 1'b0, 1'b0);
    check("async pc_plus4_d", bus.pc_plus4_d, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    pin("post-reset", 32'h0050_0093, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
